// File: rtl/axi_pkg.sv
// Shared AXI definitions for the read responder.
//   - burst encodings, response codes, responder FSM states
//   - axi_next_addr: address of the beat following `cur` within a burst
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } axi_burst_e;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rsp_state_e;

  // Beats are always 8 bytes on this fabric.
  localparam logic [63:0] AXI_BEAT_BYTES = 64'd8;

  // All arithmetic wraps modulo 2^64; callers truncate to their own width.
  function automatic logic [63:0] axi_next_addr(input logic [63:0] cur,
                                                input logic [7:0]  len,
                                                input logic [1:0]  burst);
    logic [63:0] total;
    logic [63:0] mask;
    logic [63:0] nxt;
    total = ({56'd0, len} + 64'd1) * AXI_BEAT_BYTES;
    mask  = total - 64'd1;
    case (burst)
      FIXED:   nxt = cur;
      WRAP:    nxt = (cur & ~mask) | ((cur + AXI_BEAT_BYTES) & mask);
      default: nxt = cur + AXI_BEAT_BYTES;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axi_rd_responder_if.sv
// AXI4 read address + read data channels.
//   slave  : responder side (drives arready and the R channel)
//   master : initiator side (drives AR and rready)
interface axi_rd_responder_if #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_r_skid.sv
// Two-entry FIFO holding R-channel beats.
//   clk, reset_n      : clock, async active-low reset (pointers/count only)
//   push, push_data   : write one entry
//   pop               : drop the head entry
//   head_data         : head entry, forced to zero while empty
//   full, empty       : occupancy flags
module axi_r_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] buf_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  // A push onto a full FIFO is only legal when the head leaves the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) buf_q[wr_ptr_q] <= push_data;
  end

  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'd2);
  assign head_data = empty ? '0 : buf_q[rd_ptr_q];
endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder in front of a synchronous, one-cycle-latency memory.
// One outstanding burst; FIXED/INCR/WRAP; full R backpressure.
//   clk, reset_n : clock, async active-low reset
//   s_axi        : AR/R channels (slave modport)
//   mem_req      : memory read strobe, mem_addr: word address
//   mem_rdata    : memory data, valid the cycle after mem_req
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter int          ID_WIDTH   = 13,
  parameter int          ADDR_WIDTH = 64,
  parameter int          DATA_WIDTH = 64,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int          MEM_WORDS  = 1024,
  parameter int          MEM_AW     = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  axi_rd_responder_if.slave     s_axi,
  output logic                  mem_req,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int FIFO_W     = DATA_WIDTH + 3;
  localparam logic [ADDR_WIDTH-1:0] BASE  = BASE_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] LIMIT = BASE + ADDR_WIDTH'(MEM_WORDS * BEAT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(BEAT_BYTES - 1);

  rsp_state_e            state_q, state_d;
  logic                  arready_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic                  slverr_q;
  logic [8:0]            beats_left_q;

  logic                  vld_p0, mem_p0, last_p0;
  logic [1:0]            resp_p0;

  logic                  ar_hs, ar_slverr, beat_dec, issue, issue_last, pop;
  logic [1:0]            issue_resp, occ;
  logic                  fifo_full, fifo_empty;
  logic [FIFO_W-1:0]     head_data, push_data;

  assign ar_hs = s_axi.arvalid && arready_q;
  assign pop   = !fifo_empty && s_axi.rready;

  always_comb begin
    ar_slverr = (s_axi.arsize != 3'(BEAT_SHIFT)) || (s_axi.arburst == 2'd3) ||
                ((s_axi.arburst == WRAP) && !(s_axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    beat_dec  = (addr_q < BASE) || (addr_q >= LIMIT);
    occ       = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    // Credit counts the FIFO plus the read in flight; a same-cycle pop frees a
    // slot so bursts stream one beat per cycle under rready=1.
    issue     = (state_q == BURST) && (beats_left_q != 9'd0) &&
                (({1'b0, occ} + {2'b00, vld_p0} - {2'b00, pop}) < 3'd2);
    mem_req   = issue && !slverr_q && !beat_dec;
    issue_resp = slverr_q ? SLVERR : (beat_dec ? DECERR : OKAY);
    issue_last = (beats_left_q == 9'd1);
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = BURST;
      BURST:   if (pop && head_data[0]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr = MEM_AW'((addr_q - BASE) >> BEAT_SHIFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      arready_q    <= 1'b0;
      id_q         <= '0;
      beats_left_q <= 9'd0;
      vld_p0       <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= (state_d == IDLE);
      if (ar_hs) begin
        id_q         <= s_axi.arid;
        beats_left_q <= {1'b0, s_axi.arlen} + 9'd1;
      end else if (issue) begin
        beats_left_q <= beats_left_q - 9'd1;
      end
      vld_p0 <= issue;
    end
  end

  // ---- stage p0: beat issued, memory read in flight ----
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      addr_q   <= s_axi.araddr & ALIGN;
      len_q    <= s_axi.arlen;
      burst_q  <= s_axi.arburst;
      slverr_q <= ar_slverr;
    end else if (issue) begin
      addr_q <= ADDR_WIDTH'(axi_next_addr(64'(addr_q), len_q, burst_q));
    end
    mem_p0  <= mem_req;
    resp_p0 <= issue_resp;
    last_p0 <= issue_last;
  end

  // ---- stage p1: beat lands in the R FIFO ----
  assign push_data = {(mem_p0 ? mem_rdata : '0), resp_p0, last_p0};

  axi_r_skid #(.WIDTH(FIFO_W)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (vld_p0),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = !fifo_empty;
  assign s_axi.rid     = id_q;
  assign s_axi.rdata   = head_data[FIFO_W-1:3];
  assign s_axi.rresp   = head_data[2:1];
  assign s_axi.rlast   = head_data[0];
endmodule

// File: tb/tb_axi_rd_responder.sv
`timescale 1ns/1ps
module tb_axi_rd_responder;
  import axi_pkg::*;

  localparam int IDW = 13;
  localparam int AW  = 64;
  localparam int DW  = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [IDW-1:0] arid = '0;
  logic [AW-1:0]  araddr = '0;
  logic [7:0]     arlen = '0;
  logic [2:0]     arsize = 3'd3;
  logic [1:0]     arburst = 2'd1;
  logic           arvalid = 1'b0;
  logic           rready = 1'b1;

  axi_rd_responder_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  axi_rd_responder_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.arid = arid;     assign bus1.arid = arid;
  assign bus0.araddr = araddr; assign bus1.araddr = araddr;
  assign bus0.arlen = arlen;   assign bus1.arlen = arlen;
  assign bus0.arsize = arsize; assign bus1.arsize = arsize;
  assign bus0.arburst = arburst; assign bus1.arburst = arburst;
  assign bus0.arvalid = arvalid; assign bus1.arvalid = arvalid;
  assign bus0.rready = rready; assign bus1.rready = rready;

  logic          mreq0, mreq1;
  logic [9:0]    maddr0;
  logic [3:0]    maddr1;
  logic [DW-1:0] mrdata0, mrdata1;

  axi_rd_responder u_dut (
    .clk(clk), .reset_n(reset_n), .s_axi(bus0),
    .mem_req(mreq0), .mem_addr(maddr0), .mem_rdata(mrdata0)
  );

  axi_rd_responder #(.MEM_WORDS(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .s_axi(bus1),
    .mem_req(mreq1), .mem_addr(maddr1), .mem_rdata(mrdata1)
  );

  function automatic logic [63:0] mem_word(input logic [63:0] idx);
    return {16'hC0DE, idx[15:0], (idx[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F};
  endfunction

  always @(posedge clk) begin
    if (mreq0) mrdata0 <= mem_word(64'(maddr0));
    if (mreq1) mrdata1 <= mem_word(64'(maddr1));
  end

  // observed DUT selected by sel
  logic sel = 1'b0;
  logic           m_rvalid, m_rlast, m_arready, m_req;
  logic [DW-1:0]  m_rdata;
  logic [1:0]     m_rresp;
  logic [IDW-1:0] m_rid;
  logic [31:0]    m_addr;
  assign m_rvalid  = sel ? bus1.rvalid  : bus0.rvalid;
  assign m_rlast   = sel ? bus1.rlast   : bus0.rlast;
  assign m_arready = sel ? bus1.arready : bus0.arready;
  assign m_rdata   = sel ? bus1.rdata   : bus0.rdata;
  assign m_rresp   = sel ? bus1.rresp   : bus0.rresp;
  assign m_rid     = sel ? bus1.rid     : bus0.rid;
  assign m_req     = sel ? mreq1 : mreq0;
  assign m_addr    = sel ? 32'(maddr1) : 32'(maddr0);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0]    data;
    logic [1:0]     resp;
    logic           last;
    logic [IDW-1:0] id;
  } beat_t;

  beat_t       sb[$];
  int unsigned memq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // rready driver: 0 = held high, 1 = pattern 1,0,0,1,...
  int rr_mode = 0;
  int rr_ph = 0;
  always @(posedge clk) begin
    #1;
    if (rr_mode == 1) begin
      rready = (rr_ph == 0) || (rr_ph == 3);
      rr_ph  = (rr_ph + 1) % 4;
    end else begin
      rready = 1'b1;
    end
  end

  // monitor
  int acc = 0, iss = 0, first_hs = 0, last_hs = 0, rlast_cyc = 0;
  bit credit_chk = 1'b0;
  logic hold_v = 1'b0;
  logic [63:0] hold_d;
  logic [1:0] hold_r;
  logic hold_l;
  beat_t mon_e;

  always @(negedge clk) begin
    if (reset_n) begin
      if (m_req) begin
        if (memq.size() == 0) chk("mem_req_unexpected", 1, 0);
        else chk("mem_addr", 64'(m_addr), 64'(memq.pop_front()));
        if (credit_chk) chk("credit", 64'((iss - acc - int'(m_rvalid && rready)) < 2), 1);
        iss++;
      end
      if (hold_v) begin
        chk("hold_rvalid", 64'(m_rvalid), 1);
        chk("hold_rdata", m_rdata, hold_d);
        chk("hold_rresp", 64'(m_rresp), 64'(hold_r));
        chk("hold_rlast", 64'(m_rlast), 64'(hold_l));
      end
      hold_v = m_rvalid && !rready;
      hold_d = m_rdata;
      hold_r = m_rresp;
      hold_l = m_rlast;
      if (m_rvalid && rready) begin
        if (sb.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("rdata", m_rdata, mon_e.data);
          chk("rresp", 64'(m_rresp), 64'(mon_e.resp));
          chk("rlast", 64'(m_rlast), 64'(mon_e.last));
          chk("rid", 64'(m_rid), 64'(mon_e.id));
        end
        if (acc == 0) first_hs = cyc;
        last_hs = cyc;
        if (m_rlast) rlast_cyc = cyc;
        acc++;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  int ar_cyc = 0;

  task automatic send_ar(input logic [IDW-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int mem_words);
    logic [63:0] start, a, total, lo;
    bit slv;
    bit got;
    beat_t b;
    start = addr & ~64'h7;
    total = (64'(len) + 64'd1) * 64'd8;
    slv = (size != 3'd3) || (burst == 2'd3) ||
          ((burst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    for (int i = 0; i <= int'(len); i++) begin
      if (burst == 2'd0)      a = start;
      else if (burst == 2'd1) a = start + 64'(i) * 64'd8;
      else begin
        lo = start - (start % total);
        a  = lo + ((start - lo + 64'(i) * 64'd8) % total);
      end
      b.last = (i == int'(len));
      b.id   = id;
      if (slv) begin
        b.data = '0; b.resp = SLVERR;
      end else if (a >= 64'(mem_words) * 64'd8) begin
        b.data = '0; b.resp = DECERR;
      end else begin
        b.data = mem_word(a >> 3); b.resp = OKAY;
        memq.push_back(32'(a >> 3));
      end
      sb.push_back(b);
    end
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (m_arready) begin got = 1'b1; break; end
    end
    if (!got) chk("ar_timeout", 0, 1);
    ar_cyc = cyc;
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && memq.size() == 0) break;
    end
    chk({tag, "_beats_left"}, 64'(sb.size()), 0);
    chk({tag, "_reads_left"}, 64'(memq.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_arready", 64'(m_arready), 0);
    chk("rst_rvalid", 64'(m_rvalid), 0);
    chk("rst_rlast", 64'(m_rlast), 0);
    chk("rst_rresp", 64'(m_rresp), 0);
    chk("rst_rid", 64'(m_rid), 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_mem_req", 64'(m_req), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("idle_arready", 64'(m_arready), 1);

    // 1: WRAP len=7 with latency and back-to-back checks
    acc = 0; iss = 0;
    send_ar(13'h1A5, 64'h1018, 8'd7, 3'd3, 2'd2, 1024);
    @(negedge clk);
    chk("t1_arready_drop", 64'(m_arready), 0);
    chk("t1_first_mem_req", 64'(m_req), 1);
    chk("t1_rvalid_n1", 64'(m_rvalid), 0);
    @(negedge clk);
    chk("t1_rvalid_n2", 64'(m_rvalid), 0);
    @(negedge clk);
    chk("t1_rvalid_n3", 64'(m_rvalid), 1);
    drain("t1");
    chk("t1_beats", 64'(acc), 8);
    chk("t1_b2b_span", 64'(last_hs - first_hs), 7);

    // 2: INCR len=3 under backpressure
    acc = 0; iss = 0; credit_chk = 1'b1; rr_mode = 1; rr_ph = 0;
    send_ar(13'h0042, 64'h0, 8'd3, 3'd3, 2'd1, 1024);
    drain("t2");
    chk("t2_beats", 64'(acc), 4);
    credit_chk = 1'b0; rr_mode = 0;
    repeat (2) @(negedge clk);

    // 3: whole-burst SLVERR cases
    acc = 0; iss = 0;
    send_ar(13'h0007, 64'h40, 8'd3, 3'd2, 2'd1, 1024);
    drain("t3a");
    chk("t3a_beats", 64'(acc), 4);
    chk("t3a_mem_req", 64'(iss), 0);
    acc = 0; iss = 0;
    send_ar(13'h0008, 64'h40, 8'd2, 3'd3, 2'd2, 1024);
    drain("t3b");
    chk("t3b_beats", 64'(acc), 3);
    chk("t3b_mem_req", 64'(iss), 0);

    // 4: DECERR beyond a 16-word memory
    sel = 1'b1;
    acc = 0; iss = 0;
    send_ar(13'h0ABC, 64'h70, 8'd3, 3'd3, 2'd1, 16);
    drain("t4");
    chk("t4_beats", 64'(acc), 4);
    chk("t4_mem_req", 64'(iss), 2);
    sel = 1'b0;
    repeat (2) @(negedge clk);

    // 5: reset in the middle of a burst
    acc = 0; iss = 0;
    send_ar(13'h0155, 64'h100, 8'd7, 3'd3, 2'd1, 1024);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (acc >= 3) break;
    end
    chk("t5_beats_before_reset", 64'(acc), 3);
    reset_n = 1'b0;
    #1;
    chk("t5_rvalid_in_reset", 64'(m_rvalid), 0);
    chk("t5_arready_in_reset", 64'(m_arready), 0);
    chk("t5_mem_req_in_reset", 64'(m_req), 0);
    sb.delete();
    memq.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("t5_arready_after", 64'(m_arready), 1);
    acc = 0;
    send_ar(13'h0033, 64'h8, 8'd0, 3'd3, 2'd1, 1024);
    drain("t5");
    chk("t5_single_beat", 64'(acc), 1);

    // 6: FIXED burst, second AR held off until after rlast
    acc = 0; iss = 0;
    send_ar(13'h0F0F, 64'h20, 8'd3, 3'd3, 2'd0, 1024);
    send_ar(13'h0101, 64'h30, 8'd0, 3'd3, 2'd1, 1024);
    chk("t6_ar_after_rlast", 64'(ar_cyc), 64'(rlast_cyc + 1));
    drain("t6");
    chk("t6_beats", 64'(acc), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
